// File: rtl/switch_regs_pkg.sv
// Shared definitions for the switch configuration register banks.
//   dec_state_t        : bus-transaction state of a register-bank decoder
//   *_BASE / *_N_REGS  : address window of every bank on the switch config bus.
// Each window is [BASE, BASE+N_REGS). The windows must stay disjoint, because
// a bank that does not own an address stays silent and leaves the response to
// the owning bank.
package switch_regs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP     = 2'd1,
    WAIT_REL = 2'd2
  } dec_state_t;

  // Switch bank address map (8-bit config bus)
  localparam logic [7:0] SW_GLOBAL_BASE   = 8'h10;
  localparam int         SW_GLOBAL_N_REGS = 4;
  localparam logic [7:0] PORT_CFG_BASE    = 8'h20;
  localparam int         PORT_CFG_N_REGS  = 16;
  localparam logic [7:0] STATS_BASE       = 8'h40;
  localparam int         STATS_N_REGS     = 32;

  // True when two windows [base_a, base_a+n_a) and [base_b, base_b+n_b) do not overlap.
  function automatic bit windows_disjoint(input int base_a, input int n_a,
                                          input int base_b, input int n_b);
    return ((base_a + n_a) <= base_b) || ((base_b + n_b) <= base_a);
  endfunction

endpackage

// File: rtl/reg_addr_match.sv
// Combinational address-window compare for a register bank.
//   sel_en : bus request valid
//   addr   : bus address
//   hit    : request targets [BASE_ADDR, BASE_ADDR+N_REGS)
//   idx    : addr - BASE_ADDR at full address width (meaningful only with hit)
module reg_addr_match #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    N_REGS     = 4
) (
  input  logic                  sel_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] idx
);

  // The upper bound may equal 2**ADDR_WIDTH, so it needs one extra bit.
  localparam logic [ADDR_WIDTH:0] UPPER =
    (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(N_REGS);

  logic [ADDR_WIDTH:0] diff;
  logic                above_base;
  logic                below_top;

  // A borrow out of the widened subtraction means addr < BASE_ADDR.
  assign diff       = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign above_base = ~diff[ADDR_WIDTH];
  assign below_top  = ({1'b0, addr} < UPPER);
  assign hit        = sel_en && above_base && below_top;
  assign idx        = diff[ADDR_WIDTH-1:0];

endmodule

// File: rtl/reg_bank_decoder.sv
// Register-bank decoder for the switch config bus.
// Claims N_REGS addresses starting at BASE_ADDR. Every transaction that hits
// the window gets exactly one single-cycle ack. A write to a read-write register
// also gets a one-hot write strobe. A write to a read-only register gets err.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sel_en       : request valid, held by the master until it sees ack
//   wr_rd_s      : 1 = write, 0 = read
//   addr, wdata  : bus address / write data
//   reg_rd_data  : flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_en        : one-hot write strobe (registered)
//   wr_data      : registered write data, valid with wr_en, held otherwise
//   rd_data      : read data, non-zero only while ack=1
//   ack, err     : transaction done / illegal write (err only with ack)
module reg_bank_decoder
  import switch_regs_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    N_REGS     = 4,
  parameter logic [N_REGS-1:0]     RO_MASK    = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sel_en,
  input  logic                         wr_rd_s,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [N_REGS*DATA_WIDTH-1:0] reg_rd_data,
  output logic [N_REGS-1:0]            wr_en,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         ack,
  output logic                         err
);

  logic                  hit;
  logic [ADDR_WIDTH-1:0] idx;

  reg_addr_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .N_REGS     (N_REGS)
  ) u_addr_match (
    .sel_en (sel_en),
    .addr   (addr),
    .hit    (hit),
    .idx    (idx)
  );

  // Decode idx once into a one-hot vector. The strobe, the read-only lookup and
  // the read mux all come from it, so wr_en cannot be multi-hot.
  logic [N_REGS-1:0]     idx_onehot;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  ro_sel;

  always_comb begin
    idx_onehot = '0;
    rd_mux     = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == ADDR_WIDTH'(i)) begin
        idx_onehot[i] = 1'b1;
        rd_mux        = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ro_sel = |(idx_onehot & RO_MASK);

  dec_state_t            state, state_nxt;
  logic [N_REGS-1:0]     wr_en_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic [DATA_WIDTH-1:0] rd_data_nxt;
  logic                  ack_nxt;
  logic                  err_nxt;

  always_comb begin
    state_nxt   = state;
    wr_en_nxt   = '0;
    wr_data_nxt = wr_data;
    rd_data_nxt = '0;
    ack_nxt     = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = RESP;
          ack_nxt   = 1'b1;
          if (wr_rd_s) begin
            if (ro_sel) begin
              err_nxt = 1'b1;
            end else begin
              wr_en_nxt   = idx_onehot;
              wr_data_nxt = wdata;
            end
          end else begin
            rd_data_nxt = rd_mux;
          end
        end
      end
      RESP: begin
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        // The master still holds its request after the ack. Wait for it to drop
        // so that one held request cannot be decoded twice.
        if (!sel_en) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- registered state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_en   <= '0;
      wr_data <= '0;
      rd_data <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_en   <= wr_en_nxt;
      wr_data <= wr_data_nxt;
      rd_data <= rd_data_nxt;
      ack     <= ack_nxt;
      err     <= err_nxt;
    end
  end

endmodule
